// File: rtl/mc_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute over the shared memory port.
// Optional MC_BNE_EN: decode bne (op 000101) into the branch state with inverted zero test.
module mc_control #(
    parameter int unsigned TO_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       pc_en,
    output logic [1:0] PCSrc,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       AluSrcA,
    output logic [1:0] AluSrcB,
    output logic [2:0] Alucont,
    output logic       illegal_op,
    output logic       mem_err,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StRtEx   = 4'd6,
        StRtWb   = 4'd7,
        StBeqEx  = 4'd8,
        StAddiEx = 4'd9,
        StAddiWb = 4'd10,
        StJEx    = 4'd11
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam bit         ToEn    = (TO_CYCLES != 0);
    localparam logic [15:0] ToLimit = 16'(TO_CYCLES);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        wait_st;
    logic        timeout;

    assign wait_st = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
    assign timeout = ToEn && wait_st && (cnt_q == ToLimit);
    assign state   = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StFetch;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        mem_req    = 1'b0;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        pc_en      = 1'b0;
        PCSrc      = 2'b00;
        RegWrite   = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        AluSrcA    = 1'b0;
        AluSrcB    = 2'b00;
        Alucont    = 3'b000;
        illegal_op = 1'b0;
        mem_err    = 1'b0;

        // Outputs are gated by the async reset so strobes fall with rst, not the next edge.
        if (rst) begin
            if (wait_st && !mem_ready && !timeout) begin
                cnt_d = (cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
            end

            case (state_q)
                StFetch: begin
                    AluSrcB = 2'b01;
                    Alucont = 3'b010;
                    if (timeout) begin
                        mem_err = 1'b1;
                        state_d = StFetch;
                    end else begin
                        mem_req = 1'b1;
                        IRWrite = mem_ready;
                        pc_en   = mem_ready;
                        if (mem_ready) state_d = StDecode;
                    end
                end
                StDecode: begin
                    AluSrcB = 2'b11;
                    Alucont = 3'b010;
                    case (op)
                        OpLw, OpSw: state_d = StMemAdr;
                        OpRtype:    state_d = StRtEx;
                        OpBeq:      state_d = StBeqEx;
`ifdef MC_BNE_EN
                        OpBne:      state_d = StBeqEx;
`endif
                        OpAddi:     state_d = StAddiEx;
                        OpJ:        state_d = StJEx;
                        default: begin
                            illegal_op = 1'b1;
                            state_d    = StFetch;
                        end
                    endcase
                end
                StMemAdr: begin
                    AluSrcA = 1'b1;
                    AluSrcB = 2'b10;
                    Alucont = 3'b010;
                    state_d = (op == OpLw) ? StMemRd : StMemWr;
                end
                StMemRd: begin
                    IorD = 1'b1;
                    if (timeout) begin
                        mem_err = 1'b1;
                        state_d = StFetch;
                    end else begin
                        mem_req = 1'b1;
                        if (mem_ready) state_d = StMemWb;
                    end
                end
                StMemWb: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                    state_d  = StFetch;
                end
                StMemWr: begin
                    IorD = 1'b1;
                    if (timeout) begin
                        mem_err = 1'b1;
                        state_d = StFetch;
                    end else begin
                        mem_req  = 1'b1;
                        MemWrite = mem_ready;
                        if (mem_ready) state_d = StFetch;
                    end
                end
                StRtEx: begin
                    AluSrcA = 1'b1;
                    state_d = StRtWb;
                    case (funct)
                        6'b100000: Alucont = 3'b010;
                        6'b100010: Alucont = 3'b110;
                        6'b100100: Alucont = 3'b000;
                        6'b100101: Alucont = 3'b001;
                        6'b101010: Alucont = 3'b111;
                        default: begin
                            Alucont    = 3'b010;
                            illegal_op = 1'b1;
                            state_d    = StFetch;
                        end
                    endcase
                end
                StRtWb: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                    state_d  = StFetch;
                end
                StBeqEx: begin
                    AluSrcA = 1'b1;
                    Alucont = 3'b110;
                    PCSrc   = 2'b01;
`ifdef MC_BNE_EN
                    pc_en   = (op == OpBne) ? ~zero : zero;
`else
                    pc_en   = zero;
`endif
                    state_d = StFetch;
                end
                StAddiEx: begin
                    AluSrcA = 1'b1;
                    AluSrcB = 2'b10;
                    Alucont = 3'b010;
                    state_d = StAddiWb;
                end
                StAddiWb: begin
                    RegWrite = 1'b1;
                    state_d  = StFetch;
                end
                StJEx: begin
                    PCSrc   = 2'b10;
                    pc_en   = 1'b1;
                    state_d = StFetch;
                end
                default: state_d = StFetch;
            endcase
        end
    end

endmodule
